// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared package for the slice-serial adder: state encoding and default geometry.
package adder_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SLICE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Handshake/operand bundle for nibble_serial_adder_ctrl.
// Optional overflow flag is present only with ADDER_OVF_FLAG_EN.
interface nibble_serial_adder_ctrl_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             inputc;
    logic [WIDTH-1:0] sum;
    logic             outc;
    logic             busy;
    logic             done;
`ifdef ADDER_OVF_FLAG_EN
    logic             overflow;
`endif

    modport master (
        output start,
        output sub,
        output input1,
        output input2,
        output inputc,
        input  sum,
        input  outc,
        input  busy,
`ifdef ADDER_OVF_FLAG_EN
        input  overflow,
`endif
        input  done
    );

    modport slave (
        input  start,
        input  sub,
        input  input1,
        input  input2,
        input  inputc,
        output sum,
        output outc,
        output busy,
`ifdef ADDER_OVF_FLAG_EN
        output overflow,
`endif
        output done
    );

endinterface

// File: rtl/nibble_serial_adder_ctrl_slice.sv
// SLICE-bit ripple-carry adder slice; cmsb (carry into the MSB) exists only
// with ADDER_OVF_FLAG_EN, where the top uses it for signed overflow.
module adder_slice4
    import adder_pkg::*;
#(
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
`ifdef ADDER_OVF_FLAG_EN
    output logic             cmsb,
`endif
    output logic             cout
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < SLICE; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[SLICE];
`ifdef ADDER_OVF_FLAG_EN
    assign cmsb = c[SLICE-1];
`endif

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/sub reusing one SLICE-bit slice, LSB slice first.
// Define ADDER_OVF_FLAG_EN to add the registered signed-overflow flag.
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SLICE = DEF_SLICE
) (
    input  logic                        clk,
    input  logic                        reset,
    nibble_serial_adder_ctrl_if.slave   bus
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CW     = $clog2(NSLICE);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    if ((WIDTH % SLICE) != 0 || NSLICE < 2) begin : g_bad_cfg
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of SLICE with at least two slices");
    end

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_s;
    logic             slice_cout;
`ifdef ADDER_OVF_FLAG_EN
    logic             slice_cmsb;
`endif

    assign slice_a = a_reg[cnt*SLICE +: SLICE];
    assign slice_b = b_reg[cnt*SLICE +: SLICE];

    adder_slice4 #(
        .SLICE (SLICE)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
`ifdef ADDER_OVF_FLAG_EN
        .cmsb (slice_cmsb),
`endif
        .cout (slice_cout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                accept    = bus.start;
                state_nxt = bus.start ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            carry        <= 1'b0;
            cnt          <= '0;
            bus.sum      <= '0;
            bus.outc     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
`ifdef ADDER_OVF_FLAG_EN
            bus.overflow <= 1'b0;
`endif
        end else begin
            bus.busy <= (state_nxt == ST_RUN);
            bus.done <= (state_nxt == ST_DONE);
            if (accept) begin
                a_reg <= bus.input1;
                b_reg <= bus.sub ? ~bus.input2 : bus.input2;
                carry <= bus.sub | bus.inputc;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                bus.sum[cnt*SLICE +: SLICE] <= slice_s;
                carry <= slice_cout;
                cnt   <= cnt + 1'b1;
                if (last) begin
                    bus.outc     <= slice_cout;
`ifdef ADDER_OVF_FLAG_EN
                    bus.overflow <= slice_cmsb ^ slice_cout;
`endif
                end
            end
        end
    end

endmodule
